// File: rtl/tmds_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tmds_pkg                                                  |
// | Brief    : Shared constants, types and helpers for the TMDS encoder. |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
package tmds_pkg;

   // Lane widths
   localparam int TMDS_DATA_W = 8;
   localparam int TMDS_SYM_W  = 10;

   // Running disparity is a signed 5-bit value; the encoder keeps it within +/-10
   localparam int DISP_W = 5;

   typedef logic signed [DISP_W-1:0] disp_t;

   localparam disp_t DISP_ZERO  = 5'sd0;
   localparam disp_t DISP_TWO   = 5'sd2;
   localparam disp_t DISP_EIGHT = 5'sd8;

   // Control-period symbols, indexed by {c1, c0}
   localparam logic [TMDS_SYM_W-1:0] TMDS_CTRL_00 = 10'h354;
   localparam logic [TMDS_SYM_W-1:0] TMDS_CTRL_01 = 10'h0AB;
   localparam logic [TMDS_SYM_W-1:0] TMDS_CTRL_10 = 10'h154;
   localparam logic [TMDS_SYM_W-1:0] TMDS_CTRL_11 = 10'h2AB;

   // Stage-1 pipeline word: transition-minimised byte plus the control fields
   typedef struct packed {
      logic [8:0] qm;
      logic       blank;
      logic       c1;
      logic       c0;
   } qm_word_t;

   // Number of ones in a byte (0..8)
   function automatic logic [3:0] popcount8(input logic [7:0] v);
      logic [3:0] n;
      n = 4'd0;
      for (int i = 0; i < 8; i++) begin
         n = n + {3'b000, v[i]};
      end
      return n;
   endfunction

   // Control symbol selected by the two control bits
   function automatic logic [TMDS_SYM_W-1:0] ctrl_symbol(input logic c1, input logic c0);
      logic [TMDS_SYM_W-1:0] s;
      case ({c1, c0})
         2'b00:   s = TMDS_CTRL_00;
         2'b01:   s = TMDS_CTRL_01;
         2'b10:   s = TMDS_CTRL_10;
         default: s = TMDS_CTRL_11;
      endcase
      return s;
   endfunction

endpackage
`default_nettype wire

// File: rtl/tmds_qm_stage.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tmds_qm_stage                                             |
// | Brief    : Stage 1 of the TMDS encoder - XOR/XNOR transition        |
// |            minimisation of the pixel byte, registered together with  |
// |            the blank and control bits.                               |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module tmds_qm_stage
   import tmds_pkg::*;
(
   input  logic       clk_i,
   input  logic       rst_n_i,
   input  logic [7:0] data_i,
   input  logic       c0_i,
   input  logic       c1_i,
   input  logic       blank_i,
   output qm_word_t   word_o
);

   logic [3:0] n1;
   logic       use_xnor;
   qm_word_t   word_d;
   qm_word_t   word_q;

   // Pick the chain that yields fewer transitions, then build qm bit by bit
   always_comb begin
      word_d       = '0;
      n1           = popcount8(data_i);
      use_xnor     = (n1 > 4'd4) || ((n1 == 4'd4) && !data_i[0]);
      word_d.qm[0] = data_i[0];
      for (int i = 1; i < 8; i++) begin
         word_d.qm[i] = use_xnor ? ~(word_d.qm[i-1] ^ data_i[i])
                                 :  (word_d.qm[i-1] ^ data_i[i]);
      end
      // qm[8] flags the chain used so the decoder can undo it
      word_d.qm[8] = ~use_xnor;
      word_d.blank = blank_i;
      word_d.c1    = c1_i;
      word_d.c0    = c0_i;
   end

   // Stage-1 register; reset looks like a control-00 period
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         word_q.qm    <= 9'd0;
         word_q.blank <= 1'b1;
         word_q.c1    <= 1'b0;
         word_q.c0    <= 1'b0;
      end else begin
         word_q <= word_d;
      end
   end

   assign word_o = word_q;

endmodule
`default_nettype wire

// File: rtl/tmds_encoder_8b10b.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tmds_encoder_8b10b                                        |
// | Brief    : Single-lane DVI/TMDS 8b/10b encoder. Stage 1 performs    |
// |            transition minimisation, stage 2 DC balancing against a   |
// |            signed running disparity. Two-cycle latency, one symbol   |
// |            every pixel clock.                                        |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module tmds_encoder_8b10b
   import tmds_pkg::*;
(
   input  logic       clk_pixel,
   input  logic       rst_n,
   input  logic [7:0] in_data,
   input  logic       in_c0,
   input  logic       in_c1,
   input  logic       in_blank,
   output logic [9:0] out_symbol
);

   qm_word_t   st1;

   logic [3:0] n1;
   disp_t      n1_s;
   disp_t      n0_s;
   disp_t      diff;
   logic       qm8;
   logic [7:0] qm;

   logic [9:0] sym_d;
   logic [9:0] sym_q;
   disp_t      cnt_d;
   disp_t      cnt_q;

   tmds_qm_stage u_qm_stage (
      .clk_i   (clk_pixel),
      .rst_n_i (rst_n),
      .data_i  (in_data),
      .c0_i    (in_c0),
      .c1_i    (in_c1),
      .blank_i (in_blank),
      .word_o  (st1)
   );

   // Stage 2: choose inversion to steer the running disparity back to zero
   always_comb begin
      qm    = st1.qm[7:0];
      qm8   = st1.qm[8];
      n1    = popcount8(qm);
      n1_s  = disp_t'({1'b0, n1});
      n0_s  = DISP_EIGHT - n1_s;
      diff  = n1_s - n0_s;
      sym_d = TMDS_CTRL_00;
      cnt_d = cnt_q;

      if (st1.blank) begin
         // Control periods restart the disparity so each active line starts balanced
         sym_d = ctrl_symbol(st1.c1, st1.c0);
         cnt_d = DISP_ZERO;
      end else if ((cnt_q == DISP_ZERO) || (diff == DISP_ZERO)) begin
         sym_d = {~qm8, qm8, (qm8 ? qm : ~qm)};
         cnt_d = qm8 ? (cnt_q + diff) : (cnt_q - diff);
      end else if (((cnt_q > DISP_ZERO) && (diff > DISP_ZERO)) ||
                   ((cnt_q < DISP_ZERO) && (diff < DISP_ZERO))) begin
         // Same sign as the running excess: invert the payload
         sym_d = {1'b1, qm8, ~qm};
         cnt_d = cnt_q + (qm8 ? DISP_TWO : DISP_ZERO) - diff;
      end else begin
         sym_d = {1'b0, qm8, qm};
         cnt_d = cnt_q - (qm8 ? DISP_ZERO : DISP_TWO) + diff;
      end
   end

   // Stage-2 register: output symbol and running disparity
   always_ff @(posedge clk_pixel or negedge rst_n) begin
      if (!rst_n) begin
         sym_q <= TMDS_CTRL_00;
         cnt_q <= DISP_ZERO;
      end else begin
         sym_q <= sym_d;
         cnt_q <= cnt_d;
      end
   end

   assign out_symbol = sym_q;

endmodule
`default_nettype wire

// File: tb/tb_tmds_encoder_8b10b.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tb_tmds_encoder_8b10b                                     |
// | Brief    : Self-checking bench for the TMDS lane encoder.            |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module tb_tmds_encoder_8b10b;

   logic       clk_pixel = 1'b0;
   logic       rst_n;
   logic [7:0] in_data;
   logic       in_c0;
   logic       in_c1;
   logic       in_blank;
   logic [9:0] out_symbol;

   int n_checks = 0;
   int n_errors = 0;

   // Reference state: what the DUT should show after the next edge
   logic [9:0] pend_sym;
   int         pend_cnt;
   int         model_cnt;
   logic       pend_blank;
   logic       pend_c1;
   logic       pend_c0;
   logic [7:0] pend_data;

   typedef struct {
      logic       blank;
      logic       c1;
      logic       c0;
      logic [7:0] data;
      logic [9:0] exp_sym;
      int         exp_cnt;
   } vec_t;

   vec_t tbl [12];

   tmds_encoder_8b10b dut (
      .clk_pixel  (clk_pixel),
      .rst_n      (rst_n),
      .in_data    (in_data),
      .in_c0      (in_c0),
      .in_c1      (in_c1),
      .in_blank   (in_blank),
      .out_symbol (out_symbol)
   );

   always #5 clk_pixel = ~clk_pixel;

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_errors++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t",
                  name, act, act, exp, exp, $time);
      end
   endtask

   // Behavioural encoder: minimise transitions, then pick inversion so the
   // symbol's ones/zeros excess opposes the running disparity
   function automatic void ref_encode(input logic b, input logic c1, input logic c0,
                                      input logic [7:0] d, input int cnt,
                                      output logic [9:0] sym, output int cnt_o);
      logic [9:0] ctrl [4];
      logic [1:0] idx;
      int         ones;
      int         n1;
      int         n0;
      int         bias;
      logic       xn;
      logic [7:0] q;
      logic       q8;
      ctrl = '{10'h354, 10'h0AB, 10'h154, 10'h2AB};
      idx  = {c1, c0};
      sym  = 10'h000;
      cnt_o = 0;
      if (b) begin
         sym   = ctrl[idx];
         cnt_o = 0;
      end else begin
         ones = 0;
         for (int i = 0; i < 8; i++) ones += int'(d[i]);
         xn   = (ones > 4) || (ones == 4 && d[0] == 1'b0);
         q[0] = d[0];
         for (int i = 1; i < 8; i++) q[i] = xn ? ~(q[i-1] ^ d[i]) : (q[i-1] ^ d[i]);
         q8 = ~xn;
         n1 = 0;
         for (int i = 0; i < 8; i++) n1 += int'(q[i]);
         n0   = 8 - n1;
         bias = n1 - n0;
         if (cnt == 0 || bias == 0) begin
            sym   = {~q8, q8, (q8 ? q : ~q)};
            cnt_o = cnt + (q8 ? bias : -bias);
         end else if ((cnt > 0 && bias > 0) || (cnt < 0 && bias < 0)) begin
            sym   = {1'b1, q8, ~q};
            cnt_o = cnt + (q8 ? 2 : 0) - bias;
         end else begin
            sym   = {1'b0, q8, q};
            cnt_o = cnt - (q8 ? 0 : 2) + bias;
         end
      end
   endfunction

   // Receiver-side decode of a data symbol back to the pixel byte
   function automatic logic [7:0] ref_decode(input logic [9:0] s);
      logic [7:0] v;
      logic [7:0] d;
      v    = s[9] ? ~s[7:0] : s[7:0];
      d[0] = v[0];
      for (int i = 1; i < 8; i++) d[i] = s[8] ? (v[i] ^ v[i-1]) : ~(v[i] ^ v[i-1]);
      return d;
   endfunction

   function automatic int ref_ctrl_index(input logic [9:0] s);
      int r;
      case (s)
         10'h354: r = 0;
         10'h0AB: r = 1;
         10'h154: r = 2;
         10'h2AB: r = 3;
         default: r = -1;
      endcase
      return r;
   endfunction

   task automatic model_reset();
      pend_sym   = 10'h354;
      pend_cnt   = 0;
      model_cnt  = 0;
      pend_blank = 1'b1;
      pend_c1    = 1'b0;
      pend_c0    = 1'b0;
      pend_data  = 8'h00;
   endtask

   // Drive one input word, clock it, compare against the model, advance model
   task automatic step(input logic b, input logic c1, input logic c0, input logic [7:0] d);
      logic [9:0] s;
      int         c;
      int         dcnt;
      in_blank = b;
      in_c1    = c1;
      in_c0    = c0;
      in_data  = d;
      @(posedge clk_pixel);
      #1;
      dcnt = int'(dut.cnt_q);
      check("symbol", int'(out_symbol), int'(pend_sym));
      check("cnt", dcnt, pend_cnt);
      check("cnt_bound", (dcnt <= 10 && dcnt >= -10) ? 1 : 0, 1);
      if (pend_blank)
         check("decode_ctrl", ref_ctrl_index(out_symbol), int'({pend_c1, pend_c0}));
      else
         check("decode_data", int'(ref_decode(out_symbol)), int'(pend_data));
      ref_encode(b, c1, c0, d, model_cnt, s, c);
      pend_sym   = s;
      pend_cnt   = c;
      model_cnt  = c;
      pend_blank = b;
      pend_c1    = c1;
      pend_c0    = c0;
      pend_data  = d;
   endtask

   initial begin
      tbl[0]  = '{1'b1, 1'b0, 1'b0, 8'h00, 10'h354,  0};
      tbl[1]  = '{1'b1, 1'b0, 1'b1, 8'h00, 10'h0AB,  0};
      tbl[2]  = '{1'b1, 1'b1, 1'b0, 8'h00, 10'h154,  0};
      tbl[3]  = '{1'b1, 1'b1, 1'b1, 8'h00, 10'h2AB,  0};
      tbl[4]  = '{1'b0, 1'b0, 1'b0, 8'h00, 10'h100, -8};
      tbl[5]  = '{1'b0, 1'b0, 1'b0, 8'h00, 10'h3FF,  2};
      tbl[6]  = '{1'b0, 1'b0, 1'b0, 8'h00, 10'h100, -6};
      tbl[7]  = '{1'b1, 1'b0, 1'b0, 8'h00, 10'h354,  0};
      tbl[8]  = '{1'b0, 1'b0, 1'b0, 8'hFF, 10'h200, -8};
      tbl[9]  = '{1'b1, 1'b1, 1'b1, 8'h00, 10'h2AB,  0};
      tbl[10] = '{1'b0, 1'b0, 1'b0, 8'h55, 10'h133,  0};
      tbl[11] = '{1'b1, 1'b0, 1'b1, 8'h00, 10'h0AB,  0};

      // Reset held with random inputs: output pinned to control 00
      rst_n    = 1'b0;
      in_blank = 1'b0;
      in_c0    = 1'b0;
      in_c1    = 1'b0;
      in_data  = 8'h00;
      model_reset();
      for (int i = 0; i < 6; i++) begin
         in_data  = 8'($urandom);
         in_blank = 1'($urandom);
         in_c0    = 1'($urandom);
         in_c1    = 1'($urandom);
         @(posedge clk_pixel);
         #1;
         check("reset_symbol", int'(out_symbol), 32'h354);
         check("reset_cnt", int'(dut.cnt_q), 0);
      end
      rst_n = 1'b1;

      // First cycles after release still show the reset control symbol
      step(1'b0, 1'b0, 1'b0, 8'hA7);
      step(1'b1, 1'b0, 1'b0, 8'h00);

      // Table-driven directed vectors; each result appears one step later
      for (int i = 0; i < 12; i++) begin
         step(tbl[i].blank, tbl[i].c1, tbl[i].c0, tbl[i].data);
         if (i > 0) begin
            check("tbl_symbol", int'(out_symbol), int'(tbl[i-1].exp_sym));
            check("tbl_cnt", int'(dut.cnt_q), tbl[i-1].exp_cnt);
         end
      end
      step(1'b1, 1'b0, 1'b0, 8'h00);
      check("tbl_symbol_last", int'(out_symbol), int'(tbl[11].exp_sym));
      check("tbl_cnt_last", int'(dut.cnt_q), tbl[11].exp_cnt);

      // Asynchronous reset in the middle of a 0x00 run
      step(1'b0, 1'b0, 1'b0, 8'h00);
      step(1'b0, 1'b0, 1'b0, 8'h00);
      check("pre_reset_symbol", int'(out_symbol), 32'h100);
      #1;
      rst_n = 1'b0;
      #1;
      check("async_reset_symbol", int'(out_symbol), 32'h354);
      check("async_reset_cnt", int'(dut.cnt_q), 0);
      @(posedge clk_pixel);
      #1;
      rst_n = 1'b1;
      model_reset();
      step(1'b0, 1'b0, 1'b0, 8'h00);
      step(1'b1, 1'b0, 1'b0, 8'h00);
      check("post_reset_symbol", int'(out_symbol), 32'h100);
      check("post_reset_cnt", int'(dut.cnt_q), -8);

      // Random soak against the behavioural model
      for (int i = 0; i < 20000; i++) begin
         step(($urandom_range(0, 7) == 0) ? 1'b1 : 1'b0,
              1'($urandom), 1'($urandom), 8'($urandom));
      end
      step(1'b1, 1'b0, 1'b0, 8'h00);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire
